// File: rtl/proc_clock_controller_if.sv
// Purpose: bundles the front-panel controls and processor clock/reset outputs
//   of proc_clock_controller. master = panel/driver side, slave = controller.
// Ports: speed/run/step (master->slave); proc_clk, proc_rst_n, proc_edge,
//   halted, cycle_count (slave->master).
interface proc_clock_controller_if #(
  parameter int SPEED_W = 5,
  parameter int CNT_W   = 32
);
  logic [SPEED_W-1:0] speed;
  logic               run;
  logic               step;
  logic               proc_clk;
  logic               proc_rst_n;
  logic               proc_edge;
  logic               halted;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output speed, run, step,
    input  proc_clk, proc_rst_n, proc_edge, halted, cycle_count
  );

  modport slave (
    input  speed, run, step,
    output proc_clk, proc_rst_n, proc_edge, halted, cycle_count
  );
endinterface

// File: rtl/proc_clock_controller.sv
// Purpose: sequences processor reset and a divided processor clock
//   (half-period 2^speed clk cycles) in free-run or single-step mode.
// Latency: proc_clk rises 1 cycle after run/step is sampled in IDLE;
//   proc_rst_n rises RST_HOLD cycles after rst drops.
// Backpressure: none; run is a level, step pulses outside IDLE are dropped.
// Ports: clk, rst (sync, active high); bus = slave modport carrying
//   speed/run/step in and proc_clk/proc_rst_n/proc_edge/halted/cycle_count out.
module proc_clock_controller #(
  parameter int SPEED_W  = 5,
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  proc_clock_controller_if.slave bus
);

  typedef enum logic [1:0] {HOLD, IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             step_mode_q, step_mode_d;
  logic             proc_clk_q, proc_clk_d;
  logic             proc_rst_n_q, proc_rst_n_d;
  logic             proc_edge_q, proc_edge_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic [SPEED_W-1:0] speed_s;
  logic [CNT_W-1:0]   half_new;
  logic               half_end;
  logic               start;

  assign speed_s  = bus.speed;
  // speed is sampled only when a half-period begins, so a change never
  // stretches or shortens the half already in progress.
  assign half_new = ONE << speed_s;
  assign half_end = (counter_q == half_q - ONE);

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    half_d        = half_q;
    step_mode_d   = step_mode_q;
    proc_clk_d    = proc_clk_q;
    proc_rst_n_d  = proc_rst_n_q;
    proc_edge_d   = 1'b0;
    halted_d      = halted_q;
    cycle_count_d = cycle_count_q;
    start         = 1'b0;

    case (state_q)
      HOLD: begin
        counter_d = counter_q + ONE;
        if (counter_q == CNT_W'(RST_HOLD - 1)) begin
          proc_rst_n_d = 1'b1;
          counter_d    = '0;
          state_d      = IDLE;
        end
      end
      IDLE: begin
        // run outranks step: a simultaneous step is simply absorbed.
        if (bus.run || bus.step) begin
          start       = 1'b1;
          step_mode_d = ~bus.run;
        end
      end
      HIGH: begin
        counter_d = counter_q + ONE;
        if (half_end) begin
          proc_clk_d = 1'b0;
          counter_d  = '0;
          half_d     = half_new;
          state_d    = LOW;
        end
      end
      LOW: begin
        counter_d = counter_q + ONE;
        if (half_end) begin
          // A step period always parks, even if run rose meanwhile;
          // free-run then restarts from IDLE on the next cycle.
          if (step_mode_q || !bus.run) begin
            state_d     = IDLE;
            halted_d    = 1'b1;
            step_mode_d = 1'b0;
            counter_d   = '0;
          end else begin
            start = 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase

    // Common rising-edge launch shared by IDLE and the LOW->HIGH wrap.
    if (start) begin
      state_d       = HIGH;
      proc_clk_d    = 1'b1;
      proc_edge_d   = 1'b1;
      cycle_count_d = cycle_count_q + ONE;
      halted_d      = 1'b0;
      counter_d     = '0;
      half_d        = half_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HOLD;
      counter_q     <= '0;
      half_q        <= ONE;
      step_mode_q   <= 1'b0;
      proc_clk_q    <= 1'b0;
      proc_rst_n_q  <= 1'b0;
      proc_edge_q   <= 1'b0;
      halted_q      <= 1'b1;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      half_q        <= half_d;
      step_mode_q   <= step_mode_d;
      proc_clk_q    <= proc_clk_d;
      proc_rst_n_q  <= proc_rst_n_d;
      proc_edge_q   <= proc_edge_d;
      halted_q      <= halted_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.proc_clk    = proc_clk_q;
  assign bus.proc_rst_n  = proc_rst_n_q;
  assign bus.proc_edge   = proc_edge_q;
  assign bus.halted      = halted_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_proc_clock_controller.sv
// Purpose: table-driven check of proc_clock_controller; each vector's expected
//   outputs are queued when it is driven and compared after the next edge.
// Latency: expectations refer to outputs one clk edge after the inputs.
// Backpressure: none.
module tb_proc_clock_controller;

  localparam int SPEED_W = 5;
  localparam int CNT_W   = 32;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic [4:0]  speed;
    logic        e_clk;
    logic        e_rstn;
    logic        e_edge;
    logic        e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks;
  int   n_fail;

  proc_clock_controller_if #(.SPEED_W(SPEED_W), .CNT_W(CNT_W)) bus ();

  proc_clock_controller #(
    .SPEED_W (SPEED_W),
    .CNT_W   (CNT_W),
    .RST_HOLD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic r, input logic rn, input logic st, input int spd,
                     input logic c, input logic rstn, input logic ed, input logic h,
                     input int cnt);
    vec_t v;
    v.rst      = r;
    v.run      = rn;
    v.step     = st;
    v.speed    = 5'(spd);
    v.e_clk    = c;
    v.e_rstn   = rstn;
    v.e_edge   = ed;
    v.e_halted = h;
    v.e_cnt    = 32'(cnt);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Checker: pops the expectation queued for this edge and compares.
  int chk_idx = 0;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk("proc_clk",    chk_idx, 32'(bus.proc_clk),   32'(e.e_clk));
      chk("proc_rst_n",  chk_idx, 32'(bus.proc_rst_n), 32'(e.e_rstn));
      chk("proc_edge",   chk_idx, 32'(bus.proc_edge),  32'(e.e_edge));
      chk("halted",      chk_idx, 32'(bus.halted),     32'(e.e_halted));
      chk("cycle_count", chk_idx, bus.cycle_count,     e.e_cnt);
      chk_idx++;
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.run   = 1'b0;
    bus.step  = 1'b0;
    bus.speed = '0;

    // Reset held 3 cycles, then release: proc_rst_n rises on the 4th edge.
    for (int k = 1; k <= 3; k++) add(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 0, 0, k >= 4, 0, 1, 0);

    // speed=2 free-run: 4 high / 4 low, edge every 8; run dropped before
    // the 6th edge so the count parks at 5.
    for (int j = 1; j <= 44; j++) begin
      if (j <= 40)
        add(0, 1, 0, 2, ((j - 1) / 4) % 2 == 0, 1, (j - 1) % 8 == 0, 0, (j - 1) / 8 + 1);
      else
        add(0, 0, 0, 2, 0, 1, 0, 1, 5);
    end

    // Single step at speed=1; the second step pulse lands mid-period.
    for (int s = 1; s <= 7; s++)
      add(0, 0, (s == 1 || s == 3), 1, s <= 2, 1, s == 1, s >= 5, 6);

    // Reset mid-HIGH with cycle_count=7.
    add(0, 1, 0, 2, 1, 1, 1, 0, 7);
    add(0, 1, 0, 2, 1, 1, 0, 0, 7);
    add(1, 1, 0, 2, 0, 0, 0, 1, 0);

    // run/step held through HOLD must be ignored.
    for (int h = 1; h <= 4; h++) add(0, 1, 1, 0, 0, h == 4, 0, 1, 0);

    // run+step together in IDLE at speed=0: free-run, toggling every cycle.
    for (int g = 1; g <= 4; g++)
      add(0, 1, g == 1, 0, g % 2 == 1, 1, g % 2 == 1, 0, (g + 1) / 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1, 0, 1, 2);

    // speed=3, run dropped 2 cycles into HIGH: full 8+8 period completes.
    for (int r = 1; r <= 19; r++)
      add(0, r <= 2, 0, 3, r <= 8, 1, r == 1, r >= 17, 3);

    // speed 1->4 mid-HIGH: high half stays 2, following low half is 16.
    for (int e = 1; e <= 20; e++)
      add(0, e == 1, 0, (e == 1) ? 1 : 4, e <= 2, 1, e == 1, e >= 19, 4);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      bus.run   = vecs[i].run;
      bus.step  = vecs[i].step;
      bus.speed = vecs[i].speed;
      exp_q.push_back(vecs[i]);
    end

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain actual=%0d pending expected=0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_clock_controller.md
Name: proc_clock_controller

Overview:
- Sequences the processor's slow clock and its reset from the board clock.
- Holds the processor in reset for a fixed number of cycles after system reset, then releases it.
- Generates a divided processor clock with half-period 2^speed board cycles, in free-run or single-step mode.
- Sits between the debounced front-panel inputs and the processor; reports edge pulses and a cycle count for the display.

Parameters:
- SPEED_W, 5, width of the speed exponent input.
- CNT_W, 32, width of the divider counter and of cycle_count.
- RST_HOLD, 4, board cycles proc_rst_n stays low after rst deasserts (must be ≥1).

Ports:
- clk  input  1  board clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- speed  input  SPEED_W  half-period exponent; half-period = 2^speed clk cycles.
- run  input  1  level; high = free-run, low = halt at the end of the current period.
- step  input  1  single-cycle pulse; requests exactly one processor clock period while halted.
- proc_clk  output  1  registered processor clock.
- proc_rst_n  output  1  registered active-low processor reset.
- proc_edge  output  1  one-cycle pulse, high in the same cycle proc_clk first reads 1.
- halted  output  1  high while parked in IDLE with proc_clk low.
- cycle_count  output  CNT_W  count of proc_clk rising edges since proc_rst_n released; wraps modulo 2^CNT_W.

Behaviour:
- States: HOLD, IDLE, HIGH, LOW.
- Internal registers: counter (CNT_W), half (CNT_W, latched 2^speed), step_mode flag.
- Reset (rst=1 at posedge), takes priority over everything:
  - state=HOLD, proc_rst_n=0, proc_clk=0, proc_edge=0, halted=1.
  - counter=0, cycle_count=0, step_mode=0.
- Reset asserted in any state, including mid-period, produces the same result next cycle.
- HOLD:
  - counter increments each cycle.
  - When counter==RST_HOLD-1: proc_rst_n<=1, counter<=0, go IDLE.
  - proc_rst_n therefore first reads 1 exactly RST_HOLD cycles after the first cycle with rst=0.
  - run and step are ignored in HOLD.
- IDLE (halted=1, proc_clk=0):
  - If run=1: go HIGH, proc_clk<=1, proc_edge<=1, cycle_count++, halted<=0, counter<=0, half<=2^speed, step_mode<=0.
  - Else if step=1: same as above, but step_mode<=1.
  - run and step together: run wins; step is discarded.
  - Latency from the sampled run/step edge to proc_clk high is 1 cycle.
- HIGH:
  - counter++ each cycle.
  - When counter==half-1: proc_clk<=0, counter<=0, half<=2^speed (re-latched), go LOW.
- LOW:
  - counter++ each cycle.
  - When counter==half-1 and (step_mode=1 or run=0): go IDLE, halted<=1, step_mode<=0.
  - Else when counter==half-1: go HIGH, proc_clk<=1, proc_edge<=1, cycle_count++, counter<=0, half<=2^speed.
- proc_edge is high for exactly one cycle per rising edge; it is 0 in every other cycle.
- Free-run period is exactly 2·2^speed clk cycles, 50% duty.
- speed changes take effect only at the next half-period boundary, never mid-half.
- speed=0 gives half=1, so proc_clk toggles every cycle.
- speed≥CNT_W is not supported; the driver limits speed to ≤CNT_W-1.
- Dropping run mid-period completes the current full period (HIGH and LOW) before halting.
- step pulses outside IDLE are ignored; they are not queued.
- Raising run during a step period converts it to free-run: step_mode is ignored once run=1 at the LOW boundary? No. step_mode forces a halt at that boundary regardless of run; the next period then starts from IDLE on the following cycle.
- cycle_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- rst=1 for 3 cycles, then 0, run=0 → proc_rst_n low through cycle 3, high from cycle 4 (RST_HOLD=4); halted=1; proc_clk=0; cycle_count=0.
- speed=2, run=1 after release → proc_clk high 4 cycles, low 4 cycles, repeating; proc_edge once per 8 cycles; cycle_count reaches 5 after 5 rising edges.
- Halted, speed=1, single step pulse → exactly one period (2 high, 2 low), proc_edge once, cycle_count +1, halted returns 1 at cycle 5; a second step during the period is ignored.
- speed=3 running, run dropped 2 cycles into HIGH → period completes (8 high, 8 low total), then halted=1; no further edges.
- speed 1→4 changed mid-HIGH → current half stays 2 cycles; the LOW half that follows is 16 cycles.
- rst mid-HIGH with cycle_count=7 → next cycle proc_clk=0, proc_rst_n=0, cycle_count=0, state HOLD; run=1 and step=1 together in IDLE → free-run with step_mode=0.
